// File: rtl/lm_sm_sequencer_if.sv
// LM/SM sequencer port bundle.
// master = issuing pipeline side, slave = sequencer.
interface lm_sm_sequencer_if;
    logic        start;
    logic [15:0] ir;
    logic [15:0] base_addr;
    logic        mem_ready;
    logic        busy;
    logic        stall;
    logic [2:0]  reg_addr;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic        rf_wr;
    logic        done;

    modport master (
        output start, ir, base_addr, mem_ready,
        input  busy, stall, reg_addr, mem_addr,
        input  mem_rd, mem_wr, rf_wr, done
    );

    modport slave (
        input  start, ir, base_addr, mem_ready,
        output busy, stall, reg_addr, mem_addr,
        output mem_rd, mem_wr, rf_wr, done
    );
endinterface

// File: rtl/lm_sm_sequencer.sv
// Load/Store-Multiple sequencer: walks ir[7:0] from R0 to R7,
// one memory beat per set bit at dense consecutive addresses.
module lm_sm_sequencer (
    input  logic clk,
    input  logic rst,
    lm_sm_sequencer_if.slave bus
);
    typedef enum logic {IDLE, XFER} state_t;

    state_t      state_q;
    logic [7:0]  list_q;
    logic [15:0] addr_q;
    logic        is_load_q;
    logic        done_q;

    logic [3:0]  opcode;
    logic        go;
    logic [2:0]  low_idx;
    logic [7:0]  list_nxt;
    logic        last;
    logic        busy;

    assign opcode   = bus.ir[15:12];
    assign go       = bus.start
                    && (opcode == 4'b0110 || opcode == 4'b0111)
                    && (bus.ir[7:0] != 8'd0);
    assign list_nxt = list_q & (list_q - 8'd1);
    assign last     = (list_nxt == 8'd0);
    assign busy     = (state_q == XFER);

    // Lowest set bit of the remaining list selects this beat's register.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (list_q[i]) low_idx = 3'(i);
        end
    end

    // Sequencer FSM: latch on issue, retire one list bit per accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            list_q    <= 8'd0;
            addr_q    <= 16'd0;
            is_load_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        list_q    <= bus.ir[7:0];
                        addr_q    <= bus.base_addr;
                        is_load_q <= (opcode == 4'b0110);
                        state_q   <= XFER;
                    end
                end
                XFER: begin
                    if (bus.mem_ready) begin
                        list_q <= list_nxt;
                        addr_q <= addr_q + 16'd1;
                        if (last) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.stall    = busy;
    assign bus.reg_addr = busy ? low_idx : 3'd0;
    assign bus.mem_addr = addr_q;
    assign bus.mem_rd   = busy & is_load_q;
    assign bus.mem_wr   = busy & ~is_load_q;
    assign bus.rf_wr    = bus.mem_rd & bus.mem_ready;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Directed bench for lm_sm_sequencer.
// Inputs change and outputs are sampled just after the falling edge.
module tb_lm_sm_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    lm_sm_sequencer_if bus ();

    lm_sm_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // {busy, stall, reg_addr, mem_addr, mem_rd, mem_wr, rf_wr, done}
    function automatic logic [24:0] outs();
        return {bus.busy, bus.stall, bus.reg_addr, bus.mem_addr,
                bus.mem_rd, bus.mem_wr, bus.rf_wr, bus.done};
    endfunction

    function automatic logic [24:0] ev(
        input logic b, input logic [2:0] r, input logic [15:0] a,
        input logic rd, input logic wr, input logic rf,
        input logic d);
        return {b, b, r, a, rd, wr, rf, d};
    endfunction

    task automatic issue(input logic [15:0] i, input logic [15:0] b,
                         input logic rdy);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.ir        = i;
        bus.base_addr = b;
        bus.mem_ready = rdy;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        logic [24:0] o;
        repeat (2) @(negedge clk);
        #1;
        o = outs();
        checks++;
        if (o !== 25'd0) begin
            errors++;
            $display("FAIL reset_state got %h want %h", o, 25'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        o = outs();
        checks++;
        if (o !== 25'd0) begin
            errors++;
            $display("FAIL reset_release got %h want %h", o, 25'd0);
        end
    endtask

    task automatic test_lm();
        logic [2:0]  regs [4] = '{3'd0, 3'd2, 3'd5, 3'd7};
        logic [24:0] o, e;
        issue(16'h60A5, 16'h0100, 1'b1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            o = outs();
            e = ev(1, regs[k], 16'h0100 + 16'(k), 1, 0, 1, 0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL lm_beat%0d got %h want %h", k, o, e);
            end
        end
        @(negedge clk);
        #1;
        o = outs();
        e = ev(0, 0, 16'h0104, 0, 0, 0, 1);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL lm_done got %h want %h", o, e);
        end
        @(negedge clk);
        #1;
        o = outs();
        e = ev(0, 0, 16'h0104, 0, 0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL lm_idle got %h want %h", o, e);
        end
    endtask

    task automatic test_sm_wrap();
        logic [24:0] o, e;
        issue(16'h7080, 16'hFFFF, 1'b1);
        o = outs();
        e = ev(1, 7, 16'hFFFF, 0, 1, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL sm1_beat got %h want %h", o, e);
        end
        @(negedge clk);
        #1;
        o = outs();
        e = ev(0, 0, 16'h0000, 0, 0, 0, 1);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL sm1_done got %h want %h", o, e);
        end
        @(negedge clk);
        issue(16'h7003, 16'hFFFF, 1'b1);
        o = outs();
        e = ev(1, 0, 16'hFFFF, 0, 1, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL sm2_beat0 got %h want %h", o, e);
        end
        @(negedge clk);
        #1;
        o = outs();
        e = ev(1, 1, 16'h0000, 0, 1, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL sm2_wrap got %h want %h", o, e);
        end
        @(negedge clk);
        #1;
        o = outs();
        e = ev(0, 0, 16'h0001, 0, 0, 0, 1);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL sm2_done got %h want %h", o, e);
        end
    endtask

    task automatic test_wait();
        logic [24:0] o, e;
        int          nbusy = 0;
        issue(16'h6003, 16'h0010, 1'b0);
        for (int k = 0; k < 2; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            nbusy += bus.busy;
            o = outs();
            e = ev(1, 0, 16'h0010, 1, 0, 0, 0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wait_hold%0d got %h want %h", k, o, e);
            end
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        nbusy += bus.busy;
        o = outs();
        e = ev(1, 0, 16'h0010, 1, 0, 1, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL wait_accept got %h want %h", o, e);
        end
        @(negedge clk);
        #1;
        nbusy += bus.busy;
        o = outs();
        e = ev(1, 1, 16'h0011, 1, 0, 1, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL wait_beat1 got %h want %h", o, e);
        end
        @(negedge clk);
        #1;
        nbusy += bus.busy;
        o = outs();
        e = ev(0, 0, 16'h0012, 0, 0, 0, 1);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL wait_done got %h want %h", o, e);
        end
        checks++;
        if (nbusy != 4) begin
            errors++;
            $display("FAIL wait_busy_cycles got %0d want 4", nbusy);
        end
    endtask

    task automatic test_noop();
        logic [15:0] irs [2] = '{16'h00A5, 16'h6000};
        logic [24:0] o, e;
        e = ev(0, 0, 16'h0012, 0, 0, 0, 0);
        for (int t = 0; t < 2; t++) begin
            issue(irs[t], 16'h5555, 1'b1);
            for (int k = 0; k < 3; k++) begin
                if (k > 0) begin
                    @(negedge clk);
                    #1;
                end
                o = outs();
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL noop%0d_c%0d got %h want %h",
                             t, k, o, e);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [24:0] o, e;
        issue(16'h7001, 16'h0300, 1'b1);
        o = outs();
        e = ev(1, 0, 16'h0300, 0, 1, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL b2b_sm_beat got %h want %h", o, e);
        end
        @(negedge clk);
        #1;
        o = outs();
        e = ev(0, 0, 16'h0301, 0, 0, 0, 1);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL b2b_sm_done got %h want %h", o, e);
        end
        bus.start     = 1'b1;
        bus.ir        = 16'h6040;
        bus.base_addr = 16'h0400;
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.ir        = 16'h7003;
        bus.base_addr = 16'h0900;
        #1;
        o = outs();
        e = ev(1, 6, 16'h0400, 1, 0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL b2b_lm_first got %h want %h", o, e);
        end
        @(negedge clk);
        bus.start     = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        o = outs();
        e = ev(1, 6, 16'h0400, 1, 0, 1, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL b2b_start_ignored got %h want %h", o, e);
        end
        @(negedge clk);
        #1;
        o = outs();
        e = ev(0, 0, 16'h0401, 0, 0, 0, 1);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL b2b_lm_done got %h want %h", o, e);
        end
        @(negedge clk);
        #1;
        o = outs();
        e = ev(0, 0, 16'h0401, 0, 0, 0, 0);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL b2b_after got %h want %h", o, e);
        end
    endtask

    task automatic test_reset_mid();
        logic [24:0] o, e;
        issue(16'h70FF, 16'h0200, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                @(negedge clk);
                #1;
            end
            o = outs();
            e = ev(1, 3'(k), 16'h0200 + 16'(k), 0, 1, 0, 0);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rstmid_beat%0d got %h want %h", k, o, e);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        o = outs();
        checks++;
        if (o !== 25'd0) begin
            errors++;
            $display("FAIL rstmid_abort got %h want %h", o, 25'd0);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            o = outs();
            checks++;
            if (o !== 25'd0) begin
                errors++;
                $display("FAIL rstmid_idle%0d got %h want %h",
                         k, o, 25'd0);
            end
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.ir        = 16'h0000;
        bus.base_addr = 16'h0000;
        bus.mem_ready = 1'b0;
        test_reset();
        test_lm();
        test_sm_wrap();
        test_wait();
        test_noop();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
